// File: rtl/tft_spi_stream_master.sv
// TFT SPI stream master: panel reset sequencing followed by a valid/ready
// word stream that is shifted out MSB first, with per-word RS, CS framing
// through a last flag, inline delay tokens and slow/fast SPI clock selection.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RST_LOW   | panel RST held low for RST_PULSE_CYCLES
// RST_WAIT  | RST high, waiting RST_WAIT_CYCLES before accepting words
// IDLE      | in_ready high, waiting for a word or delay token
// SHIFT     | shifting one word, 2*DIV cycles per bit
// GAP       | CS released after a framed word, held high CS_GAP_CYCLES
// DELAY     | delay token running, pins untouched
module tft_spi_stream_master #(
  parameter int DATA_WIDTH       = 16,
  parameter int WORK_DIV         = 5,
  parameter int INIT_DIV         = 2500,
  parameter int CS_GAP_CYCLES    = 2,
  parameter int RST_PULSE_CYCLES = 1000,
  parameter int RST_WAIT_CYCLES  = 5000,
  parameter int CNT_BITS         = 24
) (
  input  logic                  MasterCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_rs,
  input  logic                  in_last,
  input  logic                  in_delay,
  input  logic                  slow_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  SPI_CLK,
  output logic                  SPI_MOSI,
  output logic                  SPI_CS,
  output logic                  RS,
  output logic                  RST,
  output logic                  busy,
  output logic                  panel_ready
);

  localparam int BIT_BITS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // All timers are down-counters reloaded with (count - 1) and finished at zero.
  localparam logic [CNT_BITS-1:0] WORK_RELOAD  = CNT_BITS'(WORK_DIV - 1);
  localparam logic [CNT_BITS-1:0] INIT_RELOAD  = CNT_BITS'(INIT_DIV - 1);
  localparam logic [CNT_BITS-1:0] GAP_RELOAD   = CNT_BITS'(CS_GAP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] PULSE_RELOAD = CNT_BITS'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] WAIT_RELOAD  = CNT_BITS'(RST_WAIT_CYCLES - 1);
  localparam logic [BIT_BITS-1:0] LAST_BIT     = BIT_BITS'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DELAY
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [BIT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  slow_q, slow_d;
  logic                  last_q, last_d;
  logic                  spi_clk_q, spi_clk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  rs_q, rs_d;
  logic                  rst_q, rst_d;
  logic                  panel_ready_q, panel_ready_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;

  logic                  cnt_zero;
  logic [CNT_BITS-1:0]   cnt_dec;
  logic [CNT_BITS-1:0]   div_reload;

  // Next-state and output logic; every output is registered from its _d.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    slow_d        = slow_q;
    last_d        = last_q;
    spi_clk_d     = spi_clk_q;
    mosi_d        = mosi_q;
    cs_d          = cs_q;
    rs_d          = rs_q;
    rst_d         = rst_q;
    panel_ready_d = panel_ready_q;

    cnt_zero   = (cnt_q == '0);
    cnt_dec    = cnt_q - 1'b1;
    // Divider is taken from the mode latched at accept, not the live input.
    div_reload = slow_q ? INIT_RELOAD : WORK_RELOAD;

    case (state_q)
      ST_RST_LOW: begin
        if (cnt_zero) begin
          state_d = ST_RST_WAIT;
          rst_d   = 1'b1;
          cnt_d   = WAIT_RELOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      ST_RST_WAIT: begin
        if (cnt_zero) begin
          state_d       = ST_IDLE;
          panel_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_delay) begin
            // A zero count still costs one cycle.
            state_d = ST_DELAY;
            cnt_d   = (in_data == '0) ? '0 : (CNT_BITS'(in_data) - 1'b1);
          end else begin
            state_d   = ST_SHIFT;
            shreg_d   = in_data;
            mosi_d    = in_data[DATA_WIDTH-1];
            cs_d      = 1'b0;
            rs_d      = in_rs;
            last_d    = in_last;
            slow_d    = slow_mode;
            spi_clk_d = 1'b0;
            bit_cnt_d = LAST_BIT;
            cnt_d     = slow_mode ? INIT_RELOAD : WORK_RELOAD;
          end
        end
      end

      ST_SHIFT: begin
        if (!cnt_zero) begin
          cnt_d = cnt_dec;
        end else if (!spi_clk_q) begin
          spi_clk_d = 1'b1;
          cnt_d     = div_reload;
        end else begin
          spi_clk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            if (last_q) begin
              state_d = ST_GAP;
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
              cnt_d   = GAP_RELOAD;
            end else begin
              // CS stays low so the next word continues the frame.
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d    = shreg_q[DATA_WIDTH-2];
            bit_cnt_d = bit_cnt_q - 1'b1;
            cnt_d     = div_reload;
          end
        end
      end

      ST_GAP, ST_DELAY: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      default: begin
        state_d = ST_RST_LOW;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      state_q       <= ST_RST_LOW;
      cnt_q         <= PULSE_RELOAD;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      slow_q        <= 1'b0;
      last_q        <= 1'b0;
      spi_clk_q     <= 1'b0;
      mosi_q        <= 1'b0;
      cs_q          <= 1'b1;
      rs_q          <= 1'b0;
      rst_q         <= 1'b0;
      panel_ready_q <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      slow_q        <= slow_d;
      last_q        <= last_d;
      spi_clk_q     <= spi_clk_d;
      mosi_q        <= mosi_d;
      cs_q          <= cs_d;
      rs_q          <= rs_d;
      rst_q         <= rst_d;
      panel_ready_q <= panel_ready_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign SPI_CLK     = spi_clk_q;
  assign SPI_MOSI    = mosi_q;
  assign SPI_CS      = cs_q;
  assign RS          = rs_q;
  assign RST         = rst_q;
  assign busy        = busy_q;
  assign panel_ready = panel_ready_q;

endmodule

// File: tb/tb_tft_spi_stream_master.sv
// Bench for tft_spi_stream_master: table of directed transfers, randomized
// transfers against a timing/bit model, reset sequence and mid-word reset.
module tb_tft_spi_stream_master;

  localparam int W     = 16;
  localparam int WDIV  = 2;
  localparam int IDIV  = 8;
  localparam int GAP   = 2;
  localparam int PULSE = 4;
  localparam int RWAIT = 6;

  logic         MasterCLK = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_rs, in_last, in_delay, slow_mode, in_valid;
  logic         in_ready, SPI_CLK, SPI_MOSI, SPI_CS, RS, RST, busy, panel_ready;

  int checks = 0;
  int errors = 0;

  // Bench-side view of the pins that persist between transfers.
  logic m_cs = 1'b1;
  logic m_rs = 1'b0;

  tft_spi_stream_master #(
    .DATA_WIDTH(W), .WORK_DIV(WDIV), .INIT_DIV(IDIV), .CS_GAP_CYCLES(GAP),
    .RST_PULSE_CYCLES(PULSE), .RST_WAIT_CYCLES(RWAIT), .CNT_BITS(24)
  ) dut (
    .MasterCLK(MasterCLK), .reset(reset), .in_data(in_data), .in_rs(in_rs),
    .in_last(in_last), .in_delay(in_delay), .slow_mode(slow_mode),
    .in_valid(in_valid), .in_ready(in_ready), .SPI_CLK(SPI_CLK),
    .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS), .RS(RS), .RST(RST), .busy(busy),
    .panel_ready(panel_ready)
  );

  always #5 MasterCLK = ~MasterCLK;

  typedef struct {
    logic [W-1:0] data;
    logic         rs;
    logic         last;
    logic         dly;
    logic         slow;
    int           exp_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycles from accept until in_ready returns, from the transfer rules.
  function automatic int model_busy(input logic [W-1:0] d, input logic last,
                                    input logic dly, input logic slow);
    if (dly) return (d == 0) ? 1 : int'(d);
    return 2 * (slow ? IDIV : WDIV) * W + (last ? GAP : 0);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk"},   SPI_CLK,     0);
    check({tag, "_mosi"},  SPI_MOSI,    0);
    check({tag, "_cs"},    SPI_CS,      1);
    check({tag, "_rs"},    RS,          0);
    check({tag, "_rst"},   RST,         0);
    check({tag, "_ready"}, in_ready,    0);
    check({tag, "_busy"},  busy,        1);
    check({tag, "_pready"}, panel_ready, 0);
  endtask

  // Called at a negedge right after reset was sampled high; releases reset
  // so the current cycle is cycle 0 of the panel reset sequence.
  task automatic reset_seq(input string tag);
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_delay  = 1'b0;
    in_data   = 16'h1234;
    in_last   = 1'b1;
    slow_mode = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("%s_rst_c%0d", tag, c),    RST,         (c >= PULSE) ? 1 : 0);
      check($sformatf("%s_pready_c%0d", tag, c), panel_ready, (c >= PULSE + RWAIT) ? 1 : 0);
      check($sformatf("%s_ready_c%0d", tag, c),  in_ready,    (c >= PULSE + RWAIT) ? 1 : 0);
      check($sformatf("%s_busy_c%0d", tag, c),   busy,        (c >= PULSE + RWAIT) ? 0 : 1);
      check($sformatf("%s_cs_c%0d", tag, c),     SPI_CS,      1);
      if (c == PULSE + RWAIT) in_valid = 1'b0;
      @(negedge MasterCLK);
    end
    m_cs = 1'b1;
    m_rs = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] d, input logic rs,
                         input logic last, input logic dly, input logic slow,
                         input int exp_busy);
    int div, wlen, k, edges, busy_cnt;
    int clk_err, cs_err, rs_err, busy_err, gap_err;
    logic prev_clk;
    logic [W-1:0] bits;
    div  = slow ? IDIV : WDIV;
    wlen = 2 * div * W;
    k = 0;
    while (in_ready !== 1'b1 && k < 5000) begin
      @(negedge MasterCLK);
      k++;
    end
    check({tag, "_ready_wait"}, (in_ready === 1'b1) ? 1 : 0, 1);
    if (in_ready !== 1'b1) return;
    in_data = d; in_rs = rs; in_last = last; in_delay = dly; slow_mode = slow;
    in_valid = 1'b1;
    @(negedge MasterCLK);
    // Scramble inputs after accept; the word in flight must ignore them.
    in_valid = 1'b0; in_data = W'($urandom); in_rs = ~rs; in_last = ~last;
    slow_mode = ~slow;
    k = 1; edges = 0; bits = '0; prev_clk = 1'b0; busy_cnt = 0;
    clk_err = 0; cs_err = 0; rs_err = 0; busy_err = 0; gap_err = 0;
    while (in_ready !== 1'b1 && k <= 20000) begin
      busy_cnt++;
      if (busy !== 1'b1) busy_err++;
      if (dly) begin
        if (SPI_CLK !== 1'b0) clk_err++;
        if (SPI_CS !== m_cs) cs_err++;
        if (RS !== m_rs) rs_err++;
      end else if (k <= wlen) begin
        if (SPI_CLK !== 1'(((k - 1) / div) % 2)) clk_err++;
        if (SPI_CS !== 1'b0) cs_err++;
        if (RS !== rs) rs_err++;
        if (SPI_CLK === 1'b1 && prev_clk === 1'b0) begin
          edges++;
          bits = {bits[W-2:0], SPI_MOSI};
        end
      end else begin
        if (SPI_CLK !== 1'b0 || SPI_CS !== 1'b1 || SPI_MOSI !== 1'b0) gap_err++;
      end
      prev_clk = SPI_CLK;
      @(negedge MasterCLK);
      k++;
    end
    check({tag, "_busy_len"}, busy_cnt, exp_busy);
    check({tag, "_busy_err"}, busy_err, 0);
    check({tag, "_clk_err"},  clk_err,  0);
    check({tag, "_cs_err"},   cs_err,   0);
    check({tag, "_rs_err"},   rs_err,   0);
    check({tag, "_gap_err"},  gap_err,  0);
    check({tag, "_edges"},    edges,    dly ? 0 : W);
    if (!dly) begin
      check({tag, "_bits"}, bits, d);
      m_cs = last;
      m_rs = rs;
    end
    check({tag, "_end_cs"},   SPI_CS,  m_cs);
    check({tag, "_end_clk"},  SPI_CLK, 0);
    check({tag, "_end_busy"}, busy,    0);
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_rs = 0; in_last = 0; in_delay = 0;
    slow_mode = 0; in_valid = 0;

    tbl[0] = '{16'h002A, 1'b0, 1'b1, 1'b0, 1'b0, 66};
    tbl[1] = '{16'hF800, 1'b1, 1'b0, 1'b0, 1'b0, 64};
    tbl[2] = '{16'h07E0, 1'b1, 1'b1, 1'b0, 1'b0, 66};
    tbl[3] = '{16'd100,  1'b0, 1'b1, 1'b1, 1'b0, 100};
    tbl[4] = '{16'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[5] = '{16'h00A5, 1'b1, 1'b1, 1'b0, 1'b1, 258};
    tbl[6] = '{16'd1,    1'b0, 1'b0, 1'b1, 1'b1, 1};

    repeat (3) @(posedge MasterCLK);
    @(negedge MasterCLK);
    check_reset_vals("por");
    reset_seq("por");

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].data, tbl[i].rs, tbl[i].last,
              tbl[i].dly, tbl[i].slow, tbl[i].exp_busy);

    for (int i = 0; i < 40; i++) begin
      int r;
      logic [W-1:0] d;
      logic rs, last, dly, slow;
      r    = int'($urandom_range(0, 9));
      dly  = (r == 0);
      slow = (r == 1);
      d    = dly ? W'($urandom_range(0, 40)) : W'($urandom);
      rs   = 1'($urandom);
      last = 1'($urandom);
      run_txn($sformatf("rnd%0d", i), d, rs, last, dly, slow,
              model_busy(d, last, dly, slow));
    end

    // Reset on the 5th rising SPI_CLK edge of a word.
    begin
      int k, edges;
      logic prev_clk;
      k = 0;
      while (in_ready !== 1'b1 && k < 5000) begin
        @(negedge MasterCLK);
        k++;
      end
      in_data = 16'hA5C3; in_rs = 1; in_last = 1; in_delay = 0; slow_mode = 0;
      in_valid = 1'b1;
      @(negedge MasterCLK);
      in_valid = 1'b0;
      edges = 0; prev_clk = 1'b0; k = 0;
      while (k < 400) begin
        if (SPI_CLK === 1'b1 && prev_clk === 1'b0) edges++;
        if (edges == 5) break;
        prev_clk = SPI_CLK;
        @(negedge MasterCLK);
        k++;
      end
      check("mid_edges", edges, 5);
      reset = 1'b1;
      @(negedge MasterCLK);
      check_reset_vals("mid");
      reset_seq("mid");
    end

    run_txn("post", tbl[0].data, tbl[0].rs, tbl[0].last, tbl[0].dly,
            tbl[0].slow, tbl[0].exp_busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
